demux_rr_sched: RTL and testbench

DEMUX_RR_SCHED -- requirements
Module: demux_rr_sched

---
 rtl/demux_rr_sched_pkg.sv | 17 +
 rtl/demux_rr_sched_pick.sv | 35 +++
 rtl/demux_rr_sched.sv | 86 ++++++++
 tb/tb_demux_rr_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_rr_sched_pkg.sv
// ============================================================================
// Module      : demux_rr_sched_pkg
// Description : Shared lane-count and mode-encoding constants for the demux.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package demux_rr_sched_pkg;

    localparam int        NUM_LANES  = 4;
    localparam int        LANE_W     = 2;
    localparam logic      MODE_RR    = 1'b0;
    localparam logic      MODE_FIXED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/demux_rr_sched_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : First set mask bit at or above ptr, wrapping 3 -> 0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import demux_rr_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] mask,
    input  logic [LANE_W-1:0]    ptr,
    output logic                 found,
    output logic [LANE_W-1:0]    lane
);

    logic [LANE_W-1:0] w_idx;

    always_comb begin
        found = 1'b0;
        lane  = '0;
        w_idx = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            // 2-bit addition wraps naturally at NUM_LANES
            w_idx = ptr + LANE_W'(i);
            if (!found && mask[w_idx]) begin
                found = 1'b1;
                lane  = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_rr_sched.sv
// ============================================================================
// Module      : demux_rr_sched
// Description : One-deep 1-to-4 demux with round-robin or fixed lane choice.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module demux_rr_sched
    import demux_rr_sched_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    input  logic                 cfg_mode,
    input  logic [LANE_W-1:0]    cfg_lane,
    input  logic [NUM_LANES-1:0] cfg_mask,
    output logic [NUM_LANES-1:0] out_valid,
    output logic [DW-1:0]        out_data,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [LANE_W-1:0]    sel,
    output logic [15:0]          xfer_cnt
);

    logic              r_hold_valid;
    logic [DW-1:0]     r_hold_data;
    logic [LANE_W-1:0] r_hold_lane;
    logic [LANE_W-1:0] r_rr_ptr;
    logic [15:0]       r_xfer_cnt;

    logic              w_pick_found;
    logic [LANE_W-1:0] w_pick_lane;
    logic              w_eligible;
    logic              w_xfer;
    logic              w_accept;
    logic [LANE_W-1:0] w_lane;

    rr_pick u_rr_pick (
        .mask  (cfg_mask),
        .ptr   (r_rr_ptr),
        .found (w_pick_found),
        .lane  (w_pick_lane)
    );

    assign w_eligible = (cfg_mode == MODE_RR) ? w_pick_found : cfg_mask[cfg_lane];
    assign w_lane     = (cfg_mode == MODE_RR) ? w_pick_lane  : cfg_lane;
    assign w_xfer     = r_hold_valid & out_ready[r_hold_lane];
    // Gated by rst_n so nothing is offered acceptance while reset is held
    assign in_ready   = rst_n & w_eligible & (~r_hold_valid | w_xfer);
    assign w_accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_lane  <= '0;
            r_rr_ptr     <= '0;
            r_xfer_cnt   <= '0;
        end else begin
            if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= in_data;
                r_hold_lane  <= w_lane;
                if (cfg_mode == MODE_RR) begin
                    r_rr_ptr <= w_pick_lane + LANE_W'(1);
                end
            end else if (w_xfer) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_hold_valid ? (NUM_LANES'(1) << r_hold_lane) : '0;
    assign out_data  = r_hold_data;
    assign sel       = r_hold_lane;
    assign xfer_cnt  = r_xfer_cnt;

endmodule

`default_nettype wire

// File: tb/tb_demux_rr_sched.sv
// ============================================================================
// Module      : tb_demux_rr_sched
// Description : Randomized and directed checks against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_demux_rr_sched;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          cfg_mode;
    logic [1:0]    cfg_lane;
    logic [3:0]    cfg_mask;
    logic [3:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_ready;
    logic [1:0]    sel;
    logic [15:0]   xfer_cnt;

    demux_rr_sched #(.DW(DW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .cfg_mode  (cfg_mode),
        .cfg_lane  (cfg_lane),
        .cfg_mask  (cfg_mask),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit m_known = 0;
    bit m_valid;
    int m_data, m_lane, m_ptr, m_cnt;

    // Samples taken at the last negedge, for directed checks
    logic          s_in_ready;
    logic [3:0]    s_valid;
    logic [DW-1:0] s_data;
    logic [1:0]    s_sel;
    logic [15:0]   s_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: inputs already driven; check at negedge, advance model at posedge
    task automatic cycle();
        bit xfer, elig, acc;
        int chosen, idx;
        @(negedge clk);
        s_in_ready = in_ready;
        s_valid    = out_valid;
        s_data     = out_data;
        s_sel      = sel;
        s_cnt      = xfer_cnt;
        xfer   = m_valid && out_ready[m_lane];
        chosen = -1;
        if (cfg_mode == 1'b1) begin
            if (cfg_mask[cfg_lane]) chosen = int'(cfg_lane);
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (chosen < 0 && cfg_mask[idx]) chosen = idx;
            end
        end
        elig = (chosen >= 0);
        acc  = rst_n && elig && (!m_valid || xfer) && in_valid;
        if (m_known) begin
            check("in_ready", 32'(in_ready), 32'(rst_n && elig && (!m_valid || xfer)));
            check("out_valid", 32'(out_valid), m_valid ? (32'd1 << m_lane) : 32'd0);
            check("out_data", 32'(out_data), 32'(m_data));
            check("sel", 32'(sel), 32'(m_lane));
            check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_known = 1;
            m_valid = 0; m_data = 0; m_lane = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (xfer) m_cnt = (m_cnt + 1) % 65536;
            if (acc) begin
                m_valid = 1;
                m_data  = int'(in_data);
                m_lane  = chosen;
                if (cfg_mode == 1'b0) m_ptr = (chosen + 1) % 4;
            end else if (xfer) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bit [1:0] lanes034 [5];
        bit [1:0] lanes035 [3];
        int guard;
        lanes034 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        lanes035 = '{2'd1, 2'd3, 2'd1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_mode = 1'b0; cfg_lane = 2'd0; cfg_mask = 4'hF; out_ready = 4'hF;
        #1;
        do_reset();

        // Round-robin across all lanes, full throughput
        for (int i = 0; i <= 5; i++) begin
            in_valid = (i < 5);
            in_data  = 8'(8'h11 * (i + 1));
            cycle();
            if (i > 0) check("rr4_lane", 32'(s_sel), 32'(lanes034[i-1]));
            if (i < 5) check("rr4_ready", 32'(s_in_ready), 32'd1);
        end
        in_valid = 1'b0;
        cycle();
        check("rr4_cnt", 32'(s_cnt), 32'd5);

        // Sparse mask skips lanes 0 and 2
        do_reset();
        cfg_mask = 4'b1010;
        for (int i = 0; i <= 3; i++) begin
            in_valid = (i < 3);
            in_data  = 8'(8'h40 + i);
            cycle();
            if (i > 0) check("rr_mask_lane", 32'(s_sel), 32'(lanes035[i-1]));
            check("rr_mask_bits", 32'(s_valid & 4'b0101), 32'd0);
        end

        // Fixed lane stalled by sink back-pressure
        do_reset();
        cfg_mode = 1'b1; cfg_lane = 2'd2; cfg_mask = 4'hF; out_ready = 4'b1011;
        in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        in_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_valid", 32'(s_valid), 32'h4);
            check("stall_data", 32'(s_data), 32'hA5);
            check("stall_ready", 32'(s_in_ready), 32'd0);
            check("stall_cnt", 32'(s_cnt), 32'd0);
        end
        in_valid = 1'b0; out_ready = 4'hF;
        cycle();
        cycle();
        check("release_valid", 32'(s_valid), 32'd0);
        check("release_cnt", 32'(s_cnt), 32'd1);

        // No eligible lane
        cfg_mode = 1'b0; cfg_mask = 4'h0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("nomask_ready", 32'(s_in_ready), 32'd0);
            check("nomask_valid", 32'(s_valid), 32'd0);
        end

        // Reset discards a held word
        cfg_mode = 1'b1; cfg_lane = 2'd1; cfg_mask = 4'hF; out_ready = 4'h0;
        in_valid = 1'b1; in_data = 8'h77;
        cycle();
        cycle();
        check("held_lane1", 32'(s_valid), 32'h2);
        do_reset();
        cfg_mode = 1'b0; cfg_mask = 4'hF; out_ready = 4'hF; in_data = 8'h99;
        in_valid = 1'b1;
        cycle();
        check("post_rst_valid", 32'(s_valid), 32'd0);
        check("post_rst_cnt", 32'(s_cnt), 32'd0);
        in_valid = 1'b0;
        cycle();
        check("post_rst_lane", 32'(s_sel), 32'd0);
        check("post_rst_lvalid", 32'(s_valid), 32'h1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = 8'($urandom);
            cfg_mode  = (i % 500 < 250) ? 1'b0 : 1'($urandom_range(0, 1));
            cfg_lane  = 2'($urandom);
            cfg_mask  = ($urandom_range(0, 15) == 0) ? 4'h0 : 4'($urandom);
            out_ready = 4'($urandom);
            cycle();
        end

        // Counter wrap
        do_reset();
        cfg_mode = 1'b0; cfg_mask = 4'hF; out_ready = 4'hF; in_valid = 1'b1;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            in_data = 8'(guard);
            cycle();
            guard++;
        end
        check("wrap_reach", 32'(m_cnt), 32'hFFFF);
        cycle();
        cycle();
        check("wrap_zero", 32'(s_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
